rx_slicer_checker: RTL and testbench
====================================

# rx_slicer_checker

Receive-side counterpart of the polyphase raised-cosine transmit filter. Takes the filter's signed sample stream, which carries 2^NB_COUNT samples per symbol, and decimates it to one sample per symbol at a selectable phase. It slices each selected sample to a bit and emits the bit with a valid strobe. It also checks the recovered bits against the transmitted reference stream at a programmable symbol latency and keeps saturating bit and error counters for BER measurement in loopback benches and on hardware.

## Interface
- NB_DATA, 8, width of the signed input sample
- NB_COUNT, 2, log2 of the oversampling factor (4 samples per symbol)
- NB_CNT, 32, width of the bit and error counters
- clock  in  1  system clock; everything is clocked on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  1 = run; 0 = freeze all state (i_clear still acts)
- i_data  in  NB_DATA  signed two's-complement filter output, one sample per enabled clock
- i_phase  in  NB_COUNT  sampling phase to decide on, range 0..2^NB_COUNT-1
- i_ref_bit  in  1  transmitted reference bit
- i_ref_valid  in  1  push i_ref_bit into the reference line (one pulse per transmitted symbol)
- i_latency  in  5  symbol delay between the reference push and the matching decision, range 0..31
- i_clear  in  1  synchronous clear of both counters
- o_bit  out  1  decided bit
- o_valid  out  1  one-cycle strobe; o_bit is new on this cycle
- o_bit_count  out  NB_CNT  number of compared decisions, saturating
- o_err_count  out  NB_CNT  number of mismatched decisions, saturating

## Operation
- Phase counter (NB_COUNT bits) increments on every enabled clock and wraps from 2^NB_COUNT-1 to 0. It is never reloaded except by reset.
- Decision event: i_enable=1 and the phase counter (pre-increment value) == i_phase.
  - Decided bit = ~i_data[NB_DATA-1]. Sample 0 maps to 1; negative samples map to 0.
- Changing i_phase mid-run takes effect at the next match. The phase counter is not disturbed, so the gap between two decisions can be anywhere from 1 to 2^NB_COUNT+... cycles during the transition; the bench must tolerate one irregular symbol period.
- Reference line: 32-bit shift register sr.
  - On i_ref_valid=1 and i_enable=1: sr <= {sr[30:0], i_ref_bit}.
  - Fill counter counts pushes and saturates at 32.
- Compare: on a decision event, ref = sr[i_latency], using the register values before this cycle's push. The compare is armed only when fill > i_latency, again using the pre-update value.
- Armed decision: o_bit_count += 1. If the decided bit != ref, o_err_count += 1 as well.
- Both counters saturate at 2^NB_CNT-1 and never wrap.
- Unarmed decisions still drive o_bit/o_valid but leave both counters unchanged.
- i_clear=1 zeroes both counters on the next edge, whatever i_enable is. Clear wins over a simultaneous increment. The fill counter and sr are unaffected.
- i_enable=0:
  - phase counter, sr and fill hold;
  - i_ref_valid is ignored;
  - o_valid=0;
  - o_bit holds.
- Reset (i_reset=0) immediately forces every register and output to 0, mid-symbol included: o_bit=0, o_valid=0, both counters 0, phase counter 0, sr 0, fill 0.

## Timing
- Latency is one clock. The sample presented at edge N with a decision event yields o_bit/o_valid after edge N, visible in cycle N+1.
- The counter update for that decision is visible in the same cycle as its o_valid.
- o_valid is high for exactly one cycle per decision. With i_enable held at 1 and i_phase constant, the strobe period is exactly 2^NB_COUNT clocks.
- After reset release, the first decision uses the (i_phase+1)-th enabled sample.
- Reset is asserted asynchronously; release is synchronized by the system integrator. No internal synchronizer is provided.
- i_latency is sampled combinationally on every decision. Changing it while running takes effect on the next decision.

## Test plan
- Reset/phase: i_phase=2, repeat samples {-5,-3,+40,-1} from reset release.
  - Required: first o_valid in cycle 4 after release with o_bit=1.
  - Then one o_valid every 4 cycles, always o_bit=1.
  - i_reset=0 mid-symbol: all outputs go to 0 before the next edge.
- Slice boundary at i_phase=0, one symbol each of 0, -1, -128, 127.
  - Required o_bit sequence: 1, 0, 0, 1.
- Loopback: drive the 20-bit pattern 10101011000011011110 through the mapped stream (+64/-64 per symbol, 4 samples each), with i_ref_valid pulsed at each symbol start and i_latency set to the measured alignment.
  - Required: o_err_count=0 and o_bit_count=20-i_latency-1.
  - Invert one symbol: o_err_count=1.
- Saturation: NB_CNT=4, 20 armed mismatching decisions.
  - Required: o_err_count=15 and o_bit_count=15, both holding.
- Clear collision: assert i_clear on the cycle of an armed mismatching decision.
  - Required: both counters read 0 on the next cycle.
- Enable freeze: deassert i_enable for 7 cycles mid-symbol.
  - Required: no o_valid while disabled; o_bit holds; strobe phase resumes exactly where it stopped, 7 cycles later.

Source files
------------

// File: rtl/rx_slicer_checker.sv
// -----------------------------------------------------------------------------
// rx_slicer_checker
//
// Receive-side slicer and BER checker for the polyphase raised-cosine transmit
// filter. The filter output carries 2^NB_COUNT samples per symbol. This block
// keeps one sample per symbol at a selectable phase and slices it to a bit on
// the sign. The bit is emitted with a one-cycle valid strobe.
//
// Each decided bit is also compared with a transmitted reference stream,
// delayed by a programmable number of symbols. Saturating bit and error
// counters are kept for BER measurement.
//
// Ports:
//   clock        system clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_enable     1 = run, 0 = freeze all state (i_clear still acts)
//   i_data       signed filter sample, one per enabled clock
//   i_phase      sampling phase to decide on (0 .. 2^NB_COUNT-1)
//   i_ref_bit    transmitted reference bit
//   i_ref_valid  push i_ref_bit into the reference line
//   i_latency    reference delay in symbols (0 .. 31)
//   i_clear      synchronous clear of both counters
//   o_bit        decided bit
//   o_valid      one-cycle strobe marking a new o_bit
//   o_bit_count  compared decisions, saturating
//   o_err_count  mismatched decisions, saturating
// -----------------------------------------------------------------------------
module rx_slicer_checker #(
  parameter int NB_DATA  = 8,
  parameter int NB_COUNT = 2,
  parameter int NB_CNT   = 32
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [NB_COUNT-1:0] i_phase,
  input  logic                i_ref_bit,
  input  logic                i_ref_valid,
  input  logic [4:0]          i_latency,
  input  logic                i_clear,
  output logic                o_bit,
  output logic                o_valid,
  output logic [NB_CNT-1:0]   o_bit_count,
  output logic [NB_CNT-1:0]   o_err_count
);

  localparam int SR_LEN  = 32;
  localparam int NB_FILL = 6;
  localparam logic [NB_FILL-1:0] FILL_MAX = 6'd32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] value);
    logic [NB_CNT-1:0] result;
    if (value == {NB_CNT{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(NB_CNT-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  // State registers
  logic [NB_COUNT-1:0] phase_r;
  logic [SR_LEN-1:0]   sr_r;
  logic [NB_FILL-1:0]  fill_r;
  logic                bit_r;
  logic                valid_r;
  logic [NB_CNT-1:0]   bit_cnt_r;
  logic [NB_CNT-1:0]   err_cnt_r;

  // Next-state values
  logic [NB_COUNT-1:0] phase_nxt_s;
  logic [SR_LEN-1:0]   sr_nxt_s;
  logic [NB_FILL-1:0]  fill_nxt_s;
  logic                bit_nxt_s;
  logic                valid_nxt_s;
  logic [NB_CNT-1:0]   bit_cnt_nxt_s;
  logic [NB_CNT-1:0]   err_cnt_nxt_s;

  // Decision-path helpers
  logic                decide_s;
  logic                slice_s;
  logic                ref_s;
  logic                armed_s;
  logic                push_s;

  // Only the sign bit of the sample matters for the slicer.
  logic [NB_DATA-2:0]  unused_data_s;
  assign unused_data_s = i_data[NB_DATA-2:0];

  // Decision, slice, reference tap and arming.
  // All of these use pre-update register values, so a push in the same cycle
  // as a decision is not yet visible to that decision.
  always_comb begin
    decide_s = i_enable && (phase_r == i_phase);
    // Non-negative samples (zero included) decide 1; negative samples decide 0.
    slice_s  = ~i_data[NB_DATA-1];
    ref_s    = sr_r[i_latency];
    // The tap at i_latency holds a real reference only after more than
    // i_latency pushes.
    armed_s  = (fill_r > {1'b0, i_latency});
    push_s   = i_enable && i_ref_valid;
  end

  // Next-state computation for the phase counter, reference line and outputs.
  always_comb begin
    phase_nxt_s   = phase_r;
    sr_nxt_s      = sr_r;
    fill_nxt_s    = fill_r;
    bit_nxt_s     = bit_r;
    valid_nxt_s   = 1'b0;
    bit_cnt_nxt_s = bit_cnt_r;
    err_cnt_nxt_s = err_cnt_r;

    // The phase counter free-runs over enabled clocks and is never reloaded.
    // A change of i_phase therefore just moves the point where the next match
    // happens.
    if (i_enable) begin
      phase_nxt_s = phase_r + {{(NB_COUNT-1){1'b0}}, 1'b1};
    end else begin
      phase_nxt_s = phase_r;
    end

    if (push_s) begin
      sr_nxt_s = {sr_r[SR_LEN-2:0], i_ref_bit};
      if (fill_r == FILL_MAX) begin
        fill_nxt_s = fill_r;
      end else begin
        fill_nxt_s = fill_r + 6'd1;
      end
    end else begin
      sr_nxt_s   = sr_r;
      fill_nxt_s = fill_r;
    end

    if (decide_s) begin
      bit_nxt_s   = slice_s;
      valid_nxt_s = 1'b1;
    end else begin
      bit_nxt_s   = bit_r;
      valid_nxt_s = 1'b0;
    end

    // Clear takes priority over any increment on the same edge.
    // Unlike the other state, it also acts while the block is disabled.
    if (i_clear) begin
      bit_cnt_nxt_s = {NB_CNT{1'b0}};
      err_cnt_nxt_s = {NB_CNT{1'b0}};
    end else if (decide_s && armed_s) begin
      bit_cnt_nxt_s = sat_inc(bit_cnt_r);
      if (slice_s != ref_s) begin
        err_cnt_nxt_s = sat_inc(err_cnt_r);
      end else begin
        err_cnt_nxt_s = err_cnt_r;
      end
    end else begin
      bit_cnt_nxt_s = bit_cnt_r;
      err_cnt_nxt_s = err_cnt_r;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      phase_r   <= {NB_COUNT{1'b0}};
      sr_r      <= {SR_LEN{1'b0}};
      fill_r    <= {NB_FILL{1'b0}};
      bit_r     <= 1'b0;
      valid_r   <= 1'b0;
      bit_cnt_r <= {NB_CNT{1'b0}};
      err_cnt_r <= {NB_CNT{1'b0}};
    end else begin
      phase_r   <= phase_nxt_s;
      sr_r      <= sr_nxt_s;
      fill_r    <= fill_nxt_s;
      bit_r     <= bit_nxt_s;
      valid_r   <= valid_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      err_cnt_r <= err_cnt_nxt_s;
    end
  end

  assign o_bit       = bit_r;
  assign o_valid     = valid_r;
  assign o_bit_count = bit_cnt_r;
  assign o_err_count = err_cnt_r;

endmodule

// File: tb/tb_rx_slicer_checker.sv
// -----------------------------------------------------------------------------
// tb_rx_slicer_checker
//
// Directed bench for rx_slicer_checker.
//
// Stimulus is applied on the falling edge. Whenever a stimulus step is a
// decision, the expected bit and the edge at which it must appear are queued.
// A monitor samples 1 ns after each rising edge and pops and compares entries.
//
// A second instance with 4-bit counters shares every input. It is used to
// observe counter saturation.
// -----------------------------------------------------------------------------
module tb_rx_slicer_checker;

  logic              clock = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_enable = 1'b0;
  logic signed [7:0] i_data = 8'sd0;
  logic [1:0]        i_phase = 2'd0;
  logic              i_ref_bit = 1'b0;
  logic              i_ref_valid = 1'b0;
  logic [4:0]        i_latency = 5'd0;
  logic              i_clear = 1'b0;
  logic              o_bit;
  logic              o_valid;
  logic [31:0]       o_bit_count;
  logic [31:0]       o_err_count;
  logic              b4_bit;
  logic              b4_valid;
  logic [3:0]        b4_bit_count;
  logic [3:0]        b4_err_count;

  always #5 clock = ~clock;

  rx_slicer_checker #(.NB_DATA(8), .NB_COUNT(2), .NB_CNT(32)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_data(i_data),
    .i_phase(i_phase), .i_ref_bit(i_ref_bit), .i_ref_valid(i_ref_valid),
    .i_latency(i_latency), .i_clear(i_clear), .o_bit(o_bit), .o_valid(o_valid),
    .o_bit_count(o_bit_count), .o_err_count(o_err_count)
  );

  rx_slicer_checker #(.NB_DATA(8), .NB_COUNT(2), .NB_CNT(4)) dut4 (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_data(i_data),
    .i_phase(i_phase), .i_ref_bit(i_ref_bit), .i_ref_valid(i_ref_valid),
    .i_latency(i_latency), .i_clear(i_clear), .o_bit(b4_bit), .o_valid(b4_valid),
    .o_bit_count(b4_bit_count), .o_err_count(b4_err_count)
  );

  typedef struct {
    logic        b;
    int unsigned at;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned edge_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          ph_model = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Count rising edges so queued strobes carry the edge they must follow.
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Monitor: pop and compare whenever the DUT strobes, and flag strobes that
  // never arrived.
  always @(posedge clock) begin
    #1;
    if (o_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", o_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("strobe_edge", edge_cnt, e.at);
        chk("o_bit", o_bit, e.b);
      end
    end else if (sb_q.size() > 0 && sb_q[0].at <= edge_cnt) begin
      chk("missing_valid", o_valid, 1'b1);
      void'(sb_q.pop_front());
    end
  end

  // One stimulus clock. If this step is a decision, the hand-supplied
  // expected bit eb is queued.
  task automatic step(input logic signed [7:0] d, input logic eb, input logic en,
                      input logic rv, input logic rb, input logic clr);
    @(negedge clock);
    i_data = d;
    i_enable = en;
    i_ref_valid = rv;
    i_ref_bit = rb;
    i_clear = clr;
    if (en) begin
      if (ph_model == int'(i_phase)) sb_q.push_back('{b: eb, at: edge_cnt + 1});
      ph_model = (ph_model + 1) % 4;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    i_reset = 1'b0;
    i_enable = 1'b0;
    i_ref_valid = 1'b0;
    i_clear = 1'b0;
    i_data = 8'sd0;
    repeat (2) @(negedge clock);
    sb_q.delete();
    i_reset = 1'b1;
    ph_model = 0;
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  logic signed [7:0] samp_t1 [4] = '{-8'sd5, -8'sd3, 8'sd40, -8'sd1};
  logic signed [7:0] samp_t2 [4] = '{8'sd0, -8'sd1, -8'sd128, 8'sd127};
  logic              exp_t2  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [19:0]       pat = 20'b10101011000011011110;

  initial begin
    logic b;
    logic signed [7:0] d;

    // Reset / phase: phase 2 picks +40 every symbol; ref 1 pushed per symbol.
    do_reset();
    i_phase = 2'd2;
    i_latency = 5'd0;
    for (int e = 0; e < 19; e++) step(samp_t1[e % 4], 1'b1, 1'b1, (e % 4) == 0, 1'b1, 1'b0);
    settle();
    chk("t1_bit_count", o_bit_count, 5);
    chk("t1_err_count", o_err_count, 0);
    chk("t1_o_bit_before_rst", o_bit, 1'b1);
    #1 i_reset = 1'b0;
    #1;
    chk("rst_o_bit", o_bit, 1'b0);
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_bit_count", o_bit_count, 0);
    chk("rst_err_count", o_err_count, 0);

    // Slice boundary at phase 0.
    do_reset();
    i_phase = 2'd0;
    for (int s = 0; s < 4; s++)
      for (int j = 0; j < 4; j++) step(samp_t2[s], exp_t2[s], 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t2_unarmed_bit_count", o_bit_count, 0);

    // Loopback: data lags the reference by 3 symbols, decided at phase 0,
    // which aligns at latency 2. Run 1 inverts the symbol carrying bit 5.
    for (int run = 0; run < 2; run++) begin
      do_reset();
      i_phase = 2'd0;
      i_latency = 5'd2;
      for (int k = 0; k < 20; k++) begin
        b = (k < 3) ? 1'b1 : pat[19 - (k - 3)];
        if (run == 1 && k == 8) b = ~b;
        d = b ? 8'sd64 : -8'sd64;
        if (k < 3) d = 8'sd0;
        for (int j = 0; j < 4; j++) step(d, b, 1'b1, j == 0, pat[19 - k], 1'b0);
      end
      step(8'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("loop_bit_count", o_bit_count, 17);
      chk("loop_err_count", o_err_count, run);
      chk("loop_bit_count4", b4_bit_count, 15);
      chk("loop_err_count4", b4_err_count, run);
    end

    // Saturation: ref 0 every cycle, data positive, so every decision
    // mismatches.
    do_reset();
    i_phase = 2'd3;
    i_latency = 5'd0;
    for (int e = 0; e < 80; e++) step(8'sd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("sat_bit_count32", o_bit_count, 20);
    chk("sat_err_count32", o_err_count, 20);
    chk("sat_bit_count4", b4_bit_count, 15);
    chk("sat_err_count4", b4_err_count, 15);
    for (int e = 0; e < 16; e++) step(8'sd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("hold_bit_count32", o_bit_count, 24);
    chk("hold_bit_count4", b4_bit_count, 15);
    chk("hold_err_count4", b4_err_count, 15);

    // Clear colliding with an armed mismatching decision.
    for (int e = 0; e < 4; e++) step(8'sd10, 1'b1, 1'b1, 1'b1, 1'b0, e == 3);
    settle();
    chk("clr_bit_count", o_bit_count, 0);
    chk("clr_err_count", o_err_count, 0);
    chk("clr_bit_count4", b4_bit_count, 0);
    for (int e = 0; e < 4; e++) step(8'sd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("post_clr_bit_count", o_bit_count, 1);
    chk("post_clr_err_count", o_err_count, 1);

    // Enable freeze: 7 disabled cycles right after the symbol-2 decision.
    // Opposite-sign data is driven while disabled.
    do_reset();
    i_phase = 2'd1;
    for (int e = 0; e < 20; e++) begin
      b = ((e / 4) % 2) == 0;
      d = b ? 8'sd20 : -8'sd20;
      step(d, b, 1'b1, 1'b0, 1'b0, 1'b0);
      if (e == 9) begin
        for (int f = 0; f < 7; f++) step(-8'sd20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("freeze_o_bit_hold", o_bit, 1'b1);
        chk("freeze_o_valid", o_valid, 1'b0);
      end
    end
    for (int e = 0; e < 4; e++) step(8'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
